// File: rtl/cache_pkg.sv
// Shared types and opcodes for the L2 writeback path.
// Opcodes match the L2 opcode_out encoding.
package cache_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    // Entry layout at the default 32-bit address/data widths
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/wb_forward_match.sv
// Newest-first address match over the writeback entries.
// Scans oldest to newest from the tail so the last hit wins.
module wb_forward_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic [$clog2(DEPTH)-1:0]     i_tail,
    input  logic [ADDR_W-1:0]            i_key,
    output logic                         o_hit,
    output logic [DATA_W-1:0]            o_data
);

    localparam int PW = $clog2(DEPTH);

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_valid[i_tail + PW'(i)] &&
                i_addr[i_tail + PW'(i)] == i_key) begin
                o_hit  = 1'b1;
                o_data = i_data[i_tail + PW'(i)];
            end
        end
    end

endmodule

// File: rtl/l2_writeback_buffer.sv
// Coalescing writeback FIFO between the L2 and data memory,
// with combinational forwarding of pending data to L2 fills.
module l2_writeback_buffer
    import cache_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [6:0]                 opcode_in,
    input  logic [ADDR_W-1:0]          address_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [ADDR_W-1:0]          ld_address_in,
    input  logic [DATA_W-1:0]          dmem_rdata_in,
    output logic [DATA_W-1:0]          data_to_L2,
    input  logic                       mem_ready,
    output logic [6:0]                 mem_opcode_out,
    output logic [ADDR_W-1:0]          mem_address_out,
    output logic [DATA_W-1:0]          mem_wdata_out,
    output logic                       buf_empty,
    output logic                       buf_full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;
    drain_state_t                 r_state;
    logic [6:0]                   r_prev_opcode;
    logic [ADDR_W-1:0]            r_last_addr;
    logic [DATA_W-1:0]            r_last_data;
    logic                         r_overflow;

    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_co_hit;
    logic [PTR_W-1:0]             w_co_idx;
    logic                         w_coalesce;
    logic                         w_alloc;
    logic                         w_drop;
    logic [CNT_W-1:0]             w_count_next;
    logic                         w_fwd_hit;
    logic [DATA_W-1:0]            w_fwd_data;

    // The L2 holds its outputs, so only a changed request is a new push
    assign w_push = (opcode_in == OPC_STORE) &&
                    ((r_prev_opcode != OPC_STORE) ||
                     (address_in != r_last_addr) ||
                     (data_in != r_last_data));
    assign w_pop  = (r_state == WRITE) && mem_ready;
    assign w_full = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_co_hit = 1'b0;
        w_co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_addr[i] == address_in &&
                !(r_state == WRITE && PTR_W'(i) == r_head)) begin
                w_co_hit = 1'b1;
                w_co_idx = PTR_W'(i);
            end
        end
    end

    assign w_coalesce   = w_push && w_co_hit;
    assign w_alloc      = w_push && !w_co_hit && (!w_full || w_pop);
    assign w_drop       = w_push && !w_co_hit && w_full && !w_pop;
    assign w_count_next = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_state       <= IDLE;
            r_prev_opcode <= '0;
            r_last_addr   <= '0;
            r_last_data   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_prev_opcode <= opcode_in;
            r_last_addr   <= address_in;
            r_last_data   <= data_in;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_coalesce) begin
                r_data[w_co_idx] <= data_in;
            end
            // A pop freeing the full slot is overwritten by the push here
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= address_in;
                r_data[r_tail]  <= data_in;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_state <= (w_count_next != '0) ? WRITE : IDLE;
        end
    end

    wb_forward_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .i_valid (r_valid),
        .i_addr  (r_addr),
        .i_data  (r_data),
        .i_tail  (r_tail),
        .i_key   (ld_address_in),
        .o_hit   (w_fwd_hit),
        .o_data  (w_fwd_data)
    );

    assign data_to_L2      = w_fwd_hit ? w_fwd_data : dmem_rdata_in;
    assign mem_opcode_out  = (r_state == WRITE) ? OPC_STORE : 7'd0;
    assign mem_address_out = r_addr[r_head];
    assign mem_wdata_out   = r_data[r_head];
    assign buf_empty       = (r_count == '0);
    assign buf_full        = w_full;
    assign overflow        = r_overflow;
    assign count           = r_count;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for l2_writeback_buffer: capture, coalesce,
// overflow, forwarding, full push+pop and reset mid-drain.
module tb_l2_writeback_buffer;

    localparam logic [6:0] STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode_in;
    logic [31:0] address_in;
    logic [31:0] data_in;
    logic [31:0] ld_address_in;
    logic [31:0] dmem_rdata_in;
    logic [31:0] data_to_L2;
    logic        mem_ready;
    logic [6:0]  mem_opcode_out;
    logic [31:0] mem_address_out;
    logic [31:0] mem_wdata_out;
    logic        buf_empty;
    logic        buf_full;
    logic        overflow;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    int snap;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    l2_writeback_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode_in       (opcode_in),
        .address_in      (address_in),
        .data_in         (data_in),
        .ld_address_in   (ld_address_in),
        .dmem_rdata_in   (dmem_rdata_in),
        .data_to_L2      (data_to_L2),
        .mem_ready       (mem_ready),
        .mem_opcode_out  (mem_opcode_out),
        .mem_address_out (mem_address_out),
        .mem_wdata_out   (mem_wdata_out),
        .buf_empty       (buf_empty),
        .buf_full        (buf_full),
        .overflow        (overflow),
        .count           (count)
    );

    always #5 clk = ~clk;

    // DMEM side: log every accepted write
    always @(posedge clk) begin
        if (mem_opcode_out == STORE && mem_ready) begin
            wq_addr.push_back(mem_address_out);
            wq_data.push_back(mem_wdata_out);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [31:0] a, input logic [31:0] d);
        opcode_in  = STORE;
        address_in = a;
        data_in    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        opcode_in     = '0;
        address_in    = '0;
        data_in       = '0;
        ld_address_in = '0;
        dmem_rdata_in = 32'h5555;
        mem_ready     = 1'b0;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", buf_empty, 1);
        chk("rst_full", buf_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_opc", mem_opcode_out, 0);
        chk("rst_addr", mem_address_out, 0);
        chk("rst_wdata", mem_wdata_out, 0);
        chk("rst_fwd", data_to_L2, 32'h5555);
        reset = 1'b0;
        tick();

        // single writeback held for five cycles
        mem_ready = 1'b1;
        wb(32'h0000_0105, 32'hDEAD_BEEF);
        tick();
        chk("sw_count1", count, 1);
        chk("sw_opc", mem_opcode_out, STORE);
        chk("sw_addr", mem_address_out, 32'h105);
        tick();
        chk("sw_count0", count, 0);
        chk("sw_empty", buf_empty, 1);
        tick();
        tick();
        tick();
        opcode_in = '0;
        tick();
        chk("sw_nwr", wq_addr.size(), 1);
        chk("sw_wa", wq_addr[0], 32'h105);
        chk("sw_wd", wq_data[0], 32'hDEAD_BEEF);
        wq_addr.delete();
        wq_data.delete();

        // coalesce onto a non-head entry
        mem_ready = 1'b0;
        wb(32'h10, 32'hA);
        tick();
        wb(32'h20, 32'hB);
        tick();
        wb(32'h20, 32'hC);
        tick();
        opcode_in = '0;
        tick();
        chk("co_count", count, 2);
        chk("co_hold_a", mem_address_out, 32'h10);
        chk("co_hold_d", mem_wdata_out, 32'hA);
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        chk("co_count0", count, 0);
        chk("co_nwr", wq_addr.size(), 2);
        chk("co_wa0", wq_addr[0], 32'h10);
        chk("co_wd0", wq_data[0], 32'hA);
        chk("co_wa1", wq_addr[1], 32'h20);
        chk("co_wd1", wq_data[1], 32'hC);
        wq_addr.delete();
        wq_data.delete();

        // forwarding, including newest-of-two for one address
        wb(32'h40, 32'h1234);
        tick();
        opcode_in     = '0;
        dmem_rdata_in = 32'h9999;
        ld_address_in = 32'h40;
        #1;
        chk("fw_hit", data_to_L2, 32'h1234);
        ld_address_in = 32'h44;
        #1;
        chk("fw_miss", data_to_L2, 32'h9999);
        tick();
        wb(32'h40, 32'h5678);
        tick();
        opcode_in     = '0;
        ld_address_in = 32'h40;
        #1;
        chk("fw_count", count, 2);
        chk("fw_newest", data_to_L2, 32'h5678);
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        chk("fw_nwr", wq_addr.size(), 2);
        chk("fw_wd0", wq_data[0], 32'h1234);
        chk("fw_wd1", wq_data[1], 32'h5678);
        chk("fw_drained", data_to_L2, 32'h9999);
        wq_addr.delete();
        wq_data.delete();

        // overflow: five distinct pushes into four slots
        for (int i = 1; i <= 5; i++) begin
            wb(32'(i * 32'h100), 32'(i));
            tick();
        end
        opcode_in = '0;
        chk("ov_full", buf_full, 1);
        chk("ov_flag", overflow, 1);
        chk("ov_count", count, 4);
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1'b0;
        tick();
        chk("ov_nwr", wq_addr.size(), 4);
        chk("ov_wa0", wq_addr[0], 32'h100);
        chk("ov_wa3", wq_addr[3], 32'h400);
        chk("ov_wd3", wq_data[3], 32'h4);
        chk("ov_empty", buf_empty, 1);
        chk("ov_sticky", overflow, 1);
        wq_addr.delete();
        wq_data.delete();

        // full buffer with push and pop in the same cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("pp_ovf0", overflow, 0);
        for (int i = 6; i <= 9; i++) begin
            wb(32'(i * 32'h100), 32'(i));
            tick();
        end
        chk("pp_full", buf_full, 1);
        mem_ready = 1'b1;
        wb(32'hA00, 32'hA);
        tick();
        opcode_in = '0;
        chk("pp_count", count, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", mem_address_out, 32'h700);
        tick();
        mem_ready = 1'b0;
        chk("rm_count3", count, 3);
        chk("rm_opc", mem_opcode_out, STORE);

        // reset while draining
        ld_address_in = 32'h800;
        dmem_rdata_in = 32'h7777;
        #1;
        chk("rm_fwd_pre", data_to_L2, 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_count", count, 0);
        chk("rm_empty", buf_empty, 1);
        chk("rm_full", buf_full, 0);
        chk("rm_ovf", overflow, 0);
        chk("rm_opc0", mem_opcode_out, 0);
        chk("rm_addr", mem_address_out, 0);
        chk("rm_wdata", mem_wdata_out, 0);
        chk("rm_fwd", data_to_L2, 32'h7777);
        snap      = wq_addr.size();
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rm_nwr", wq_addr.size(), 2);
        chk("rm_nomore", wq_addr.size(), snap);
        chk("rm_wa0", wq_addr[0], 32'h600);
        chk("rm_opc_idle", mem_opcode_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
